// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver and direction decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT  = 8'hE0;
   localparam logic [7:0] PS2_BRK  = 8'hF0;

   // Extended (E0-prefixed) arrow keys
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   // Non-extended WASD aliases
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

   // Opposite directions differ only in bit 0.
   typedef enum logic [1:0] {DIR_R, DIR_L, DIR_U, DIR_D} dir_e;

   function automatic dir_e dir_opposite(input dir_e d);
      return dir_e'(d ^ 2'b01);
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: input synchronizers, falling-edge detect, 11-bit frame FSM
// with odd-parity/stop check and an inter-edge timeout that aborts a stalled frame.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data=0 on a ps2clk fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking stop bit and parity, then back to IDLE
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 10000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2clk_i,
   input  logic       ps2data_i,
   output logic [7:0] byte_o,
   output logic       byte_ok_o,
   output logic       frame_err_o
);

   localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [SS-1:0]    clk_sync_q;
   logic [SS-1:0]    dat_sync_q;
   logic             clk_prev_q;
   frame_state_e     state_q;
   logic [3:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic             par_q;
   logic [CNT_W-1:0] tmo_cnt_q;
   logic             byte_ok_q;
   logic             err_q;

   logic fall;
   logic din;

   assign fall = clk_prev_q & ~clk_sync_q[SS-1];
   assign din  = dat_sync_q[SS-1];

   // Synchronizers reset to the idle-high line level so reset never fakes an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[SS-2:0], ps2clk_i};
         dat_sync_q <= {dat_sync_q[SS-2:0], ps2data_i};
         clk_prev_q <= clk_sync_q[SS-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_cnt_q <= '0;
         byte_ok_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         byte_ok_q <= 1'b0;
         err_q     <= 1'b0;
         if (fall) begin
            tmo_cnt_q <= '0;
            case (state_q)
               IDLE: begin
                  if (!din) begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end
               end
               DATA: begin
                  shift_q   <= {din, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) state_q <= PARITY;
               end
               PARITY: begin
                  par_q   <= din;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (din && (^{shift_q, par_q})) byte_ok_q <= 1'b1;
                  else                            err_q     <= 1'b1;
               end
               default: state_q <= IDLE;
            endcase
         end else if (state_q != IDLE) begin
            // Counter holds at its last value once it fires; IDLE stops it.
            if (tmo_cnt_q == CNT_LAST) begin
               state_q <= IDLE;
               err_q   <= 1'b1;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
         end
      end
   end

   // shift_q is untouched in IDLE, so it still holds the byte while byte_ok is high.
   assign byte_o      = shift_q;
   assign byte_ok_o   = byte_ok_q;
   assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard front end: E0/F0 prefix resolution into make/break events and
// arrow/WASD mapping onto sticky-heading or held-level direction outputs.
module ps2_dir_decoder
   import ps2_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int TIMEOUT_US    = 200,
   parameter int SYNC_STAGES   = 2,
   parameter int DIR_MODE      = 0,
   parameter int BLOCK_REVERSE = 1,
   parameter int WASD_EN       = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2clk,
   input  logic       ps2data,
   output logic [7:0] scancode,
   output logic       scan_valid,
   output logic       released,
   output logic       extended,
   output logic       err_ind,
   output logic       right,
   output logic       left,
   output logic       up,
   output logic       down
);

   localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;

   logic [7:0] rx_byte;
   logic       rx_ok;
   logic       rx_err;

   ps2_rx_frame #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk_i       (clk),
      .rst_i       (rst),
      .ps2clk_i    (ps2clk),
      .ps2data_i   (ps2data),
      .byte_o      (rx_byte),
      .byte_ok_o   (rx_ok),
      .frame_err_o (rx_err)
   );

   logic       brk_q;
   logic       ext_q;
   logic [7:0] scancode_q;
   logic       scan_valid_q;
   logic       released_q;
   logic       extended_q;
   logic [3:0] dir_q;
   logic [3:0] dir_d;
   logic       dir_hit;
   dir_e       dir_idx;

   always_comb begin
      dir_hit = 1'b0;
      dir_idx = DIR_R;
      if (ext_q) begin
         case (rx_byte)
            SC_RIGHT: begin dir_hit = 1'b1; dir_idx = DIR_R; end
            SC_LEFT:  begin dir_hit = 1'b1; dir_idx = DIR_L; end
            SC_UP:    begin dir_hit = 1'b1; dir_idx = DIR_U; end
            SC_DOWN:  begin dir_hit = 1'b1; dir_idx = DIR_D; end
            default: ;
         endcase
      end else if (WASD_EN != 0) begin
         case (rx_byte)
            SC_D: begin dir_hit = 1'b1; dir_idx = DIR_R; end
            SC_A: begin dir_hit = 1'b1; dir_idx = DIR_L; end
            SC_W: begin dir_hit = 1'b1; dir_idx = DIR_U; end
            SC_S: begin dir_hit = 1'b1; dir_idx = DIR_D; end
            default: ;
         endcase
      end
   end

   // Heading mode ignores breaks; held mode tracks one bit per direction,
   // so an arrow and its WASD alias share the same bit.
   always_comb begin
      dir_d = dir_q;
      if (DIR_MODE == 0) begin
         if (!brk_q && !((BLOCK_REVERSE != 0) && dir_q[dir_opposite(dir_idx)]))
            dir_d = 4'b0001 << dir_idx;
      end else begin
         dir_d[dir_idx] = !brk_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         scancode_q   <= '0;
         scan_valid_q <= 1'b0;
         released_q   <= 1'b0;
         extended_q   <= 1'b0;
         dir_q        <= '0;
      end else begin
         scan_valid_q <= 1'b0;
         if (rx_err) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
         end else if (rx_ok) begin
            if (rx_byte == PS2_BRK) begin
               brk_q <= 1'b1;
            end else if (rx_byte == PS2_EXT) begin
               ext_q <= 1'b1;
            end else begin
               scancode_q   <= rx_byte;
               released_q   <= brk_q;
               extended_q   <= ext_q;
               scan_valid_q <= 1'b1;
               brk_q        <= 1'b0;
               ext_q        <= 1'b0;
               if (dir_hit) dir_q <= dir_d;
            end
         end
      end
   end

   assign scancode   = scancode_q;
   assign scan_valid = scan_valid_q;
   assign released   = released_q;
   assign extended   = extended_q;
   assign err_ind    = rx_err;
   assign right      = dir_q[DIR_R];
   assign left       = dir_q[DIR_L];
   assign up         = dir_q[DIR_U];
   assign down       = dir_q[DIR_D];

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Directed bench: heading-mode instance (dut0) and held-level instance (dut1),
// each fed by its own PS/2 line pair.
module tb_ps2_dir_decoder;

   localparam int CLK_HZ   = 10_000_000;
   localparam int TMO_US   = 20;
   localparam int TC       = 200;
   localparam int SYNC     = 2;
   localparam int H        = 10;
   // Two sync flops, the edge register, then the scan_valid register.
   localparam int LAT_SV   = SYNC + 2;
   // Timeout fires TC cycles after the edge register captures the last fall.
   localparam int LAT_TMO  = SYNC + 1 + TC;

   logic clk, rst;
   logic ps2clk0, ps2data0, ps2clk1, ps2data1;
   logic [7:0] code0, code1;
   logic sv0, rel0, ext0, err0, r0, l0, up0, dn0;
   logic sv1, rel1, ext1, err1, r1, l1, up1, dn1;

   ps2_dir_decoder #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TMO_US), .SYNC_STAGES(SYNC),
                     .DIR_MODE(0), .BLOCK_REVERSE(1), .WASD_EN(1)) dut0 (
      .clk(clk), .rst(rst), .ps2clk(ps2clk0), .ps2data(ps2data0),
      .scancode(code0), .scan_valid(sv0), .released(rel0), .extended(ext0),
      .err_ind(err0), .right(r0), .left(l0), .up(up0), .down(dn0));

   ps2_dir_decoder #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TMO_US), .SYNC_STAGES(SYNC),
                     .DIR_MODE(1), .BLOCK_REVERSE(1), .WASD_EN(1)) dut1 (
      .clk(clk), .rst(rst), .ps2clk(ps2clk1), .ps2data(ps2data1),
      .scancode(code1), .scan_valid(sv1), .released(rel1), .extended(ext1),
      .err_ind(err1), .right(r1), .left(l1), .up(up1), .down(dn1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_errors = 0;
   int last_fall_cyc = 0;

   int sv_cnt0 = 0, err_cnt0 = 0, sv_cyc0 = 0, err_cyc0 = 0;
   int sv_cnt1 = 0, err_cnt1 = 0;
   logic [7:0] cap_code0;
   logic cap_rel0, cap_ext0;
   logic [3:0] cap_dir0;

   always @(negedge clk) begin
      if (sv0 === 1'b1) begin
         sv_cnt0++; sv_cyc0 = cyc;
         cap_code0 = code0; cap_rel0 = rel0; cap_ext0 = ext0;
         cap_dir0 = {up0, dn0, l0, r0};
      end
      if (err0 === 1'b1) begin err_cnt0++; err_cyc0 = cyc; end
      if (sv1 === 1'b1) sv_cnt1++;
      if (err1 === 1'b1) err_cnt1++;
   end

   task automatic drive(input int inst, input logic c, input logic d);
      if (inst == 0) begin ps2clk0 = c; ps2data0 = d; end
      else           begin ps2clk1 = c; ps2data1 = d; end
   endtask

   // Start, 8 data LSB first, odd parity, stop; nbits < 11 leaves the frame partial.
   task automatic send_frame(input int inst, input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk); drive(inst, 1'b1, f[i]);
         repeat (H) @(negedge clk);
         drive(inst, 1'b0, f[i]); last_fall_cyc = cyc;
         repeat (H) @(negedge clk);
         drive(inst, 1'b1, f[i]);
      end
      repeat (H) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if ({code0, sv0, rel0, ext0, err0, r0, l0, up0, dn0} !== 16'h0) begin
         n_errors++; $display("FAIL reset_dut0: outputs=%h want 0000", {code0, sv0, rel0, ext0, err0, r0, l0, up0, dn0});
      end
      n_checks++;
      if ({code1, sv1, rel1, ext1, err1, r1, l1, up1, dn1} !== 16'h0) begin
         n_errors++; $display("FAIL reset_dut1: outputs=%h want 0000", {code1, sv1, rel1, ext1, err1, r1, l1, up1, dn1});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_make_break;
      int s;
      s = sv_cnt0;
      send_frame(0, 8'hE0, 0, 11);
      send_frame(0, 8'h74, 0, 11);
      n_checks++;
      if (sv_cnt0 - s !== 1) begin n_errors++; $display("FAIL make_sv_count: got %0d want 1", sv_cnt0 - s); end
      n_checks++;
      if (sv_cyc0 - last_fall_cyc !== LAT_SV) begin
         n_errors++; $display("FAIL make_latency: got %0d want %0d", sv_cyc0 - last_fall_cyc, LAT_SV);
      end
      n_checks++;
      if ({cap_code0, cap_ext0, cap_rel0} !== {8'h74, 1'b1, 1'b0}) begin
         n_errors++; $display("FAIL make_fields: code=%h ext=%b rel=%b want 74 1 0", cap_code0, cap_ext0, cap_rel0);
      end
      n_checks++;
      if (cap_dir0 !== 4'b0001) begin n_errors++; $display("FAIL make_dir_at_valid: udlr=%b want 0001", cap_dir0); end
      s = sv_cnt0;
      send_frame(0, 8'hE0, 0, 11);
      send_frame(0, 8'hF0, 0, 11);
      send_frame(0, 8'h74, 0, 11);
      n_checks++;
      if (sv_cnt0 - s !== 1) begin n_errors++; $display("FAIL break_sv_count: got %0d want 1", sv_cnt0 - s); end
      n_checks++;
      if ({cap_code0, cap_ext0, cap_rel0} !== {8'h74, 1'b1, 1'b1}) begin
         n_errors++; $display("FAIL break_fields: code=%h ext=%b rel=%b want 74 1 1", cap_code0, cap_ext0, cap_rel0);
      end
      n_checks++;
      if ({up0, dn0, l0, r0} !== 4'b0001) begin n_errors++; $display("FAIL break_keeps_heading: udlr=%b want 0001", {up0, dn0, l0, r0}); end
   endtask

   task automatic test_block_reverse;
      send_frame(0, 8'hE0, 0, 11);
      send_frame(0, 8'h6B, 0, 11);
      n_checks++;
      if ({up0, dn0, l0, r0} !== 4'b0001) begin n_errors++; $display("FAIL reverse_blocked: udlr=%b want 0001", {up0, dn0, l0, r0}); end
      n_checks++;
      if (cap_code0 !== 8'h6B) begin n_errors++; $display("FAIL reverse_reported: code=%h want 6b", cap_code0); end
      send_frame(0, 8'hE0, 0, 11);
      send_frame(0, 8'h75, 0, 11);
      n_checks++;
      if ({up0, dn0, l0, r0} !== 4'b1000) begin n_errors++; $display("FAIL turn_up: udlr=%b want 1000", {up0, dn0, l0, r0}); end
   endtask

   task automatic test_parity_error;
      int s_sv, s_err;
      s_sv = sv_cnt0; s_err = err_cnt0;
      send_frame(0, 8'h1C, 1, 11);
      n_checks++;
      if (err_cnt0 - s_err !== 1) begin n_errors++; $display("FAIL parity_err_pulse: cycles=%0d want 1", err_cnt0 - s_err); end
      n_checks++;
      if (sv_cnt0 - s_sv !== 0) begin n_errors++; $display("FAIL parity_no_valid: got %0d want 0", sv_cnt0 - s_sv); end
      n_checks++;
      if ({up0, dn0, l0, r0} !== 4'b1000) begin n_errors++; $display("FAIL parity_no_dir: udlr=%b want 1000", {up0, dn0, l0, r0}); end
      send_frame(0, 8'h1C, 0, 11);
      n_checks++;
      if ({up0, dn0, l0, r0} !== 4'b0010) begin n_errors++; $display("FAIL wasd_left: udlr=%b want 0010", {up0, dn0, l0, r0}); end
      n_checks++;
      if ({cap_code0, cap_ext0} !== {8'h1C, 1'b0}) begin n_errors++; $display("FAIL wasd_fields: code=%h ext=%b want 1c 0", cap_code0, cap_ext0); end
   endtask

   task automatic test_timeout;
      int s_sv, s_err, k;
      s_sv = sv_cnt0; s_err = err_cnt0; k = 0;
      send_frame(0, 8'h55, 0, 5);
      while (err_cnt0 == s_err && k < 2 * TC) begin @(negedge clk); k++; end
      n_checks++;
      if (err_cnt0 == s_err) begin n_errors++; $display("FAIL timeout_seen: no err_ind within %0d cycles", 2 * TC); end
      n_checks++;
      if (err_cyc0 - last_fall_cyc !== LAT_TMO) begin
         n_errors++; $display("FAIL timeout_latency: got %0d want %0d", err_cyc0 - last_fall_cyc, LAT_TMO);
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (err_cnt0 - s_err !== 1) begin n_errors++; $display("FAIL timeout_pulse: cycles=%0d want 1", err_cnt0 - s_err); end
      n_checks++;
      if (sv_cnt0 - s_sv !== 0) begin n_errors++; $display("FAIL timeout_no_valid: got %0d want 0", sv_cnt0 - s_sv); end
      send_frame(0, 8'hE0, 0, 11);
      send_frame(0, 8'h72, 0, 11);
      n_checks++;
      if ({up0, dn0, l0, r0} !== 4'b0100) begin n_errors++; $display("FAIL recover_down: udlr=%b want 0100", {up0, dn0, l0, r0}); end
      n_checks++;
      if ({cap_code0, cap_ext0, cap_rel0} !== {8'h72, 1'b1, 1'b0}) begin
         n_errors++; $display("FAIL recover_fields: code=%h ext=%b rel=%b want 72 1 0", cap_code0, cap_ext0, cap_rel0);
      end
   endtask

   task automatic test_held;
      int s;
      s = sv_cnt1;
      send_frame(1, 8'hE0, 0, 11); send_frame(1, 8'h74, 0, 11);
      send_frame(1, 8'hE0, 0, 11); send_frame(1, 8'h6B, 0, 11);
      n_checks++;
      if ({up1, dn1, l1, r1} !== 4'b0011) begin n_errors++; $display("FAIL held_both: udlr=%b want 0011", {up1, dn1, l1, r1}); end
      n_checks++;
      if (sv_cnt1 - s !== 2) begin n_errors++; $display("FAIL held_sv_count: got %0d want 2", sv_cnt1 - s); end
      send_frame(1, 8'hE0, 0, 11); send_frame(1, 8'hF0, 0, 11); send_frame(1, 8'h74, 0, 11);
      n_checks++;
      if ({up1, dn1, l1, r1} !== 4'b0010) begin n_errors++; $display("FAIL held_break_right: udlr=%b want 0010", {up1, dn1, l1, r1}); end
      n_checks++;
      if (rel1 !== 1'b1) begin n_errors++; $display("FAIL held_released: got %b want 1", rel1); end
      send_frame(1, 8'h23, 0, 11);
      n_checks++;
      if ({up1, dn1, l1, r1} !== 4'b0011) begin n_errors++; $display("FAIL held_wasd_d: udlr=%b want 0011", {up1, dn1, l1, r1}); end
      send_frame(1, 8'hE0, 0, 11); send_frame(1, 8'hF0, 0, 11); send_frame(1, 8'h74, 0, 11);
      n_checks++;
      if ({up1, dn1, l1, r1} !== 4'b0010) begin n_errors++; $display("FAIL held_alias_break: udlr=%b want 0010", {up1, dn1, l1, r1}); end
   endtask

   task automatic test_rst_mid_frame;
      int s_sv, s_err;
      send_frame(0, 8'hE0, 0, 11);
      send_frame(0, 8'h74, 0, 4);
      @(negedge clk); rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({code0, sv0, rel0, ext0, err0, r0, l0, up0, dn0} !== 16'h0) begin
         n_errors++; $display("FAIL midrst_outputs: outputs=%h want 0000", {code0, sv0, rel0, ext0, err0, r0, l0, up0, dn0});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      s_sv = sv_cnt0; s_err = err_cnt0;
      send_frame(0, 8'h74, 0, 11);
      n_checks++;
      if (sv_cnt0 - s_sv !== 1) begin n_errors++; $display("FAIL midrst_sv_count: got %0d want 1", sv_cnt0 - s_sv); end
      n_checks++;
      if ({cap_code0, cap_ext0, cap_rel0} !== {8'h74, 1'b0, 1'b0}) begin
         n_errors++; $display("FAIL midrst_fields: code=%h ext=%b rel=%b want 74 0 0", cap_code0, cap_ext0, cap_rel0);
      end
      n_checks++;
      if ({up0, dn0, l0, r0} !== 4'b0000) begin n_errors++; $display("FAIL midrst_no_dir: udlr=%b want 0000", {up0, dn0, l0, r0}); end
      n_checks++;
      if (err_cnt0 - s_err !== 0) begin n_errors++; $display("FAIL midrst_no_err: got %0d want 0", err_cnt0 - s_err); end
   endtask

   initial begin
      rst = 1'b1;
      ps2clk0 = 1'b1; ps2data0 = 1'b1;
      ps2clk1 = 1'b1; ps2data1 = 1'b1;
      test_reset();
      test_make_break();
      test_block_reverse();
      test_parity_error();
      test_timeout();
      test_held();
      test_rst_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
- Parametrised PS/2 keyboard receiver and direction decoder; successor to the fixed-function keyboard top feeding the snake game controller.
- Receives raw ps2clk/ps2data, frames and parity-checks bytes, and resolves E0/F0 prefix sequences into make/break events.
- Maps arrow keys (plus WASD, optional) to direction outputs in sticky-heading or held-level mode, with optional reverse-direction blocking.
- Adds frame timeout recovery.

Parameters:
- CLK_HZ, 50_000_000, frequency of clk in Hz.
- TIMEOUT_US, 200, max gap between ps2clk falling edges inside a frame; TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US.
- SYNC_STAGES, 2, flip-flop stages on ps2clk and ps2data (minimum 2).
- DIR_MODE, 0, 0 = sticky heading (one-hot, latched on make), 1 = held level (bit set while key is held).
- BLOCK_REVERSE, 1, DIR_MODE 0 only: when 1, a make opposite to the current heading is ignored.
- WASD_EN, 1, when 1, W/A/S/D (1D/1C/1B/23, non-extended) alias up/left/down/right.

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst  in  1  synchronous, active-high reset
- ps2clk  in  1  raw PS/2 clock, asynchronous
- ps2data  in  1  raw PS/2 data, asynchronous
- scancode  out  8  last completed code byte, prefixes stripped
- scan_valid  out  1  one-cycle pulse when scancode/released/extended update
- released  out  1  1 = last event was a break (F0-prefixed)
- extended  out  1  1 = last event was E0-prefixed
- err_ind  out  1  one-cycle pulse on parity, stop-bit or timeout error
- right, left, up, down  out  1 each  direction outputs

Behaviour:
- Reset: all outputs 0, FSM IDLE, prefix flags clear, heading none, held bitmap 0, timeout counter 0. rst mid-frame discards the partial byte.
- Synchronizer: SYNC_STAGES flops per input. A falling edge is registered prev=1 and cur=0 on the synchronized ps2clk; data is sampled in the same cycle.
- Frame FSM:
  - IDLE: on edge, data=0 -> DATA with bit count 0; data=1 -> stay IDLE, no error.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: data=1 and odd parity over 9 bits correct -> byte_ok; otherwise err_ind pulse. Always -> IDLE.
- Timeout:
  - Counter clears on each edge and counts while not IDLE.
  - On reaching TIMEOUT_CYC-1: FSM -> IDLE, err_ind pulse, prefix flags cleared.
  - Saturates; never runs in IDLE.
- Errors also clear the E0/F0 flags. No scan_valid on any error.
- Byte handling, decided in the cycle after the stop-bit edge:
  - F0 -> brk=1.
  - E0 -> ext=1.
  - Any other byte -> scancode=byte, released=brk, extended=ext, scan_valid=1 for that cycle; then brk and ext clear.
  - Latency: scan_valid asserts 1 clk after the synchronized stop-bit falling edge.
- Key map:
  - Extended 74/6B/75/72 = right/left/up/down.
  - Non-extended WASD when WASD_EN.
  - All other codes: report on scancode only, no direction effect.
- DIR_MODE 0:
  - A make of direction d sets the heading one-hot to d.
  - If BLOCK_REVERSE and d is opposite the current heading, the make is ignored.
  - Breaks have no effect.
  - A repeated make (typematic) of the current heading gives no change.
- DIR_MODE 1:
  - A make sets held[d] and a break clears it; outputs equal held.
  - Opposite keys may both be 1.
  - An arrow and its WASD alias share one bit; either break clears it.
- Direction outputs update on the same cycle as scan_valid.
- Widths: bit count 4-bit, timeout counter clog2(TIMEOUT_CYC) bits.

Decomposition:
- Package ps2_pkg:
  - Prefix constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - Arrow and WASD scancode constants.
  - Frame FSM state enum {IDLE, DATA, PARITY, STOP}.
  - Direction index typedef {DIR_R, DIR_L, DIR_U, DIR_D}.
- Sub-module ps2_rx_frame: synchronizer, edge detect, frame FSM, parity, and timeout. It outputs byte[7:0], byte_ok pulse, and frame_err pulse.
- Prefix handling and the direction map stay in the top.

Test Plan:
- DIR_MODE 0: send E0,74 -> scan_valid 1 cycle, scancode=74, extended=1, released=0, right=1. Send E0,F0,74 -> released=1, right stays 1.
- BLOCK_REVERSE=1, heading right: send E0,6B -> left stays 0, right stays 1. Send E0,75 -> up=1, right=0.
- Frame 1C with bad parity -> err_ind single pulse, no scan_valid. Then a good 1C -> left=1 (WASD_EN=1).
- Timeout: 5 bits then idle ps2clk -> err_ind exactly TIMEOUT_CYC cycles after the last edge. Then E0,72 decodes to down=1.
- DIR_MODE 1: make 74, make 6B -> right=1 and left=1. Break 74 -> right=0, left=1. Make 23, break 74 -> right=0.
- rst asserted mid-byte after E0 -> all outputs 0. The following frame 74 decodes with extended=0 and no direction change.
